// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_fsm
// Purpose  : Moore control sequencer for the 6-instruction datapath: register
//            reads, ALU op and write-back, plus a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control_fsm #(
    parameter int CNT_W        = 16,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    output logic             w,
    output logic [2:0]       nsel,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic             loadc,
    output logic             loads,
    output logic [1:0]       vsel,
    output logic             write,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] ST_WAIT   = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_WIMM   = 4'd2;
    localparam logic [3:0] ST_GETA   = 4'd3;
    localparam logic [3:0] ST_GETB   = 4'd4;
    localparam logic [3:0] ST_ALU    = 4'd5;
    localparam logic [3:0] ST_WREG   = 4'd6;
    localparam logic [3:0] ST_STAT   = 4'd7;
    localparam logic [3:0] ST_TRAP   = 4'd8;

    // {opcode, op} encodings of the defined instructions
    localparam logic [4:0] I_MOVI = 5'b110_10;
    localparam logic [4:0] I_MOV  = 5'b110_00;
    localparam logic [4:0] I_ADD  = 5'b101_00;
    localparam logic [4:0] I_CMP  = 5'b101_01;
    localparam logic [4:0] I_AND  = 5'b101_10;
    localparam logic [4:0] I_MVN  = 5'b101_11;

    logic [3:0]       state_q, state_d;
    logic [4:0]       instr_q, instr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_legal;

    assign w_legal = (instr_q == I_MOVI) || (instr_q == I_MOV) ||
                     (instr_q == I_ADD)  || (instr_q == I_CMP) ||
                     (instr_q == I_AND)  || (instr_q == I_MVN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT;
            instr_q <= 5'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            ST_WAIT: begin
                if (s) begin
                    state_d = ST_DECODE;
                    instr_d = {opcode, op};
                end
            end
            ST_DECODE: begin
                case (instr_q)
                    I_MOVI:              state_d = ST_WIMM;
                    I_ADD, I_AND, I_CMP: state_d = ST_GETA;
                    I_MOV, I_MVN:        state_d = ST_GETB;
                    default:             state_d = ILLEGAL_TRAP ? ST_TRAP : ST_WAIT;
                endcase
            end
            ST_GETA: state_d = ST_GETB;
            ST_GETB: state_d = (instr_q == I_CMP) ? ST_STAT : ST_ALU;
            ST_ALU:  state_d = ST_WREG;
            // Every done state retires one instruction on its exit edge
            ST_WIMM, ST_WREG, ST_STAT: begin
                state_d = ST_WAIT;
                count_d = count_q + CNT_W'(1);
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        w       = 1'b0;
        nsel    = 3'b000;
        loada   = 1'b0;
        loadb   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        vsel    = 2'b00;
        write   = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            ST_WAIT:   w = 1'b1;
            ST_DECODE: illegal = !w_legal;
            ST_WIMM: begin
                nsel  = 3'b100;
                vsel  = 2'b01;
                write = 1'b1;
                done  = 1'b1;
            end
            ST_GETA: begin
                nsel  = 3'b100;
                loada = 1'b1;
            end
            ST_GETB: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            // MOV/MVN pass B alone through the ALU, so A is forced to zero
            ST_ALU: begin
                asel  = (instr_q == I_MOV) || (instr_q == I_MVN);
                loadc = 1'b1;
            end
            ST_WREG: begin
                nsel  = 3'b010;
                write = 1'b1;
                done  = 1'b1;
            end
            ST_STAT: begin
                loads = 1'b1;
                done  = 1'b1;
            end
            ST_TRAP:   illegal = 1'b1;
            default:   w = 1'b0;
        endcase
    end

    assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control_fsm
// Purpose  : Directed self-checking bench for cpu_control_fsm (default,
//            trapping and narrow-counter instances share one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control_fsm;

    // Packed view: {w, nsel[2:0], loada, loadb, asel, bsel, loadc, loads, vsel[1:0], write, done, illegal}
    localparam logic [14:0] E_WAIT  = 15'b1_000_0_0_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_DEC   = 15'b0_000_0_0_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_DECI  = 15'b0_000_0_0_0_0_0_0_00_0_0_1;
    localparam logic [14:0] E_WIMM  = 15'b0_100_0_0_0_0_0_0_01_1_1_0;
    localparam logic [14:0] E_GETA  = 15'b0_100_1_0_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_GETB  = 15'b0_001_0_1_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_ALUA  = 15'b0_000_0_0_0_0_1_0_00_0_0_0;
    localparam logic [14:0] E_ALUM  = 15'b0_000_0_0_1_0_1_0_00_0_0_0;
    localparam logic [14:0] E_WREG  = 15'b0_010_0_0_0_0_0_0_00_1_1_0;
    localparam logic [14:0] E_STAT  = 15'b0_000_0_0_0_0_0_1_00_0_1_0;
    localparam logic [14:0] E_TRAP  = 15'b0_000_0_0_0_0_0_0_00_0_0_1;

    logic       clk;
    logic       reset_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;

    logic        w, loada, loadb, asel, bsel, loadc, loads, write, done, illegal;
    logic [2:0]  nsel;
    logic [1:0]  vsel;
    logic [15:0] instr_count;

    logic        t_w, t_loada, t_loadb, t_asel, t_bsel, t_loadc, t_loads, t_write, t_done, t_illegal;
    logic [2:0]  t_nsel;
    logic [1:0]  t_vsel;
    logic [15:0] t_instr_count;

    logic        n_w, n_loada, n_loadb, n_asel, n_bsel, n_loadc, n_loads, n_write, n_done, n_illegal;
    logic [2:0]  n_nsel;
    logic [1:0]  n_vsel;
    logic [1:0]  n_instr_count;

    logic [14:0] obs, obs_t, obs_n;
    assign obs   = {w, nsel, loada, loadb, asel, bsel, loadc, loads, vsel, write, done, illegal};
    assign obs_t = {t_w, t_nsel, t_loada, t_loadb, t_asel, t_bsel, t_loadc, t_loads, t_vsel,
                    t_write, t_done, t_illegal};
    assign obs_n = {n_w, n_nsel, n_loada, n_loadb, n_asel, n_bsel, n_loadc, n_loads, n_vsel,
                    n_write, n_done, n_illegal};

    int errors = 0;
    int checks = 0;
    bit watch_write = 1'b0;
    bit write_seen  = 1'b0;

    cpu_control_fsm #(.CNT_W(16), .ILLEGAL_TRAP(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .loadc(loadc), .loads(loads), .vsel(vsel), .write(write), .done(done),
        .illegal(illegal), .instr_count(instr_count)
    );

    cpu_control_fsm #(.CNT_W(16), .ILLEGAL_TRAP(1'b1)) dut_trap (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(t_w), .nsel(t_nsel), .loada(t_loada), .loadb(t_loadb), .asel(t_asel), .bsel(t_bsel),
        .loadc(t_loadc), .loads(t_loads), .vsel(t_vsel), .write(t_write), .done(t_done),
        .illegal(t_illegal), .instr_count(t_instr_count)
    );

    cpu_control_fsm #(.CNT_W(2), .ILLEGAL_TRAP(1'b0)) dut_narrow (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(n_w), .nsel(n_nsel), .loada(n_loada), .loadb(n_loadb), .asel(n_asel), .bsel(n_bsel),
        .loadc(n_loadc), .loads(n_loads), .vsel(n_vsel), .write(n_write), .done(n_done),
        .illegal(n_illegal), .instr_count(n_instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(write) if (watch_write && write) write_seen = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] oc, input logic [1:0] o);
        opcode = oc;
        op     = o;
        s      = 1'b1;
        tick();
        s      = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        s = 1'b0; opcode = 3'b000; op = 2'b00;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== E_WAIT) begin errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs, E_WAIT); end
        checks++;
        if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (obs !== E_WAIT) begin errors++; $display("FAIL reset_idle obs=%b exp=%b", obs, E_WAIT); end
    endtask

    task automatic test_mov_imm();
        logic [14:0] seq [3];
        seq = '{E_DEC, E_WIMM, E_WAIT};
        start(3'b110, 2'b10);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== seq[i]) begin errors++; $display("FAIL movi[%0d] obs=%b exp=%b", i, obs, seq[i]); end
            if (i < 2) tick();
        end
        checks++;
        if (instr_count !== 16'd1) begin errors++; $display("FAIL movi_count got=%0d exp=1", instr_count); end
    endtask

    task automatic test_add();
        logic [14:0] seq [6];
        seq = '{E_DEC, E_GETA, E_GETB, E_ALUA, E_WREG, E_WAIT};
        start(3'b101, 2'b00);
        opcode = 3'b111; op = 2'b11;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs !== seq[i]) begin errors++; $display("FAIL add[%0d] obs=%b exp=%b", i, obs, seq[i]); end
            if (i < 5) tick();
        end
        checks++;
        if (instr_count !== 16'd2) begin errors++; $display("FAIL add_count got=%0d exp=2", instr_count); end
    endtask

    task automatic test_cmp();
        logic [14:0] seq [5];
        seq = '{E_DEC, E_GETA, E_GETB, E_STAT, E_WAIT};
        start(3'b101, 2'b01);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== seq[i]) begin errors++; $display("FAIL cmp[%0d] obs=%b exp=%b", i, obs, seq[i]); end
            if (i < 4) tick();
        end
        checks++;
        if (instr_count !== 16'd3) begin errors++; $display("FAIL cmp_count got=%0d exp=3", instr_count); end
    endtask

    task automatic test_mvn_mov(input logic [2:0] oc, input logic [1:0] o, input logic [15:0] cnt);
        logic [14:0] seq [5];
        seq = '{E_DEC, E_GETB, E_ALUM, E_WREG, E_WAIT};
        start(oc, o);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== seq[i]) begin
                errors++; $display("FAIL mvn_mov_%b%b[%0d] obs=%b exp=%b", oc, o, i, obs, seq[i]);
            end
            if (i < 4) tick();
        end
        checks++;
        if (instr_count !== cnt) begin errors++; $display("FAIL mvn_mov_count got=%0d exp=%0d", instr_count, cnt); end
    endtask

    task automatic test_illegal();
        start(3'b111, 2'b00);
        checks++;
        if (obs !== E_DECI) begin errors++; $display("FAIL illegal_decode obs=%b exp=%b", obs, E_DECI); end
        checks++;
        if (obs_t !== E_DECI) begin errors++; $display("FAIL trap_decode obs=%b exp=%b", obs_t, E_DECI); end
        tick();
        checks++;
        if (obs !== E_WAIT) begin errors++; $display("FAIL illegal_return obs=%b exp=%b", obs, E_WAIT); end
        checks++;
        if (instr_count !== 16'd5) begin errors++; $display("FAIL illegal_count got=%0d exp=5", instr_count); end
        opcode = 3'b110; op = 2'b10;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_t !== E_TRAP) begin errors++; $display("FAIL trap_hold[%0d] obs=%b exp=%b", i, obs_t, E_TRAP); end
            s = (i == 1);
            tick();
        end
        s = 1'b0;
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs_t !== E_WAIT) begin errors++; $display("FAIL trap_reset obs=%b exp=%b", obs_t, E_WAIT); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [14:0] seq [6];
        seq = '{E_DEC, E_GETA, E_GETB, E_ALUA, E_WREG, E_WAIT};
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) begin
                tick();
                checks++;
                if (obs !== seq[i]) begin errors++; $display("FAIL b2b[%0d][%0d] obs=%b exp=%b", k, i, obs, seq[i]); end
                if (i == 1) begin opcode = 3'b110; op = 2'b10; end
                if (i == 4) begin opcode = 3'b101; op = 2'b00; end
                if (k == 2 && i == 5) s = 1'b0;
            end
        end
        tick();
        checks++;
        if (obs !== E_WAIT) begin errors++; $display("FAIL b2b_idle obs=%b exp=%b", obs, E_WAIT); end
        checks++;
        if (instr_count !== 16'd3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", instr_count); end
    endtask

    task automatic test_reset_mid();
        start(3'b101, 2'b10);
        tick(); tick();
        checks++;
        if (obs !== E_GETB) begin errors++; $display("FAIL and_getb obs=%b exp=%b", obs, E_GETB); end
        write_seen  = 1'b0;
        watch_write = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== E_WAIT) begin errors++; $display("FAIL midreset_async obs=%b exp=%b", obs, E_WAIT); end
        checks++;
        if (instr_count !== 16'd0) begin errors++; $display("FAIL midreset_count got=%0d exp=0", instr_count); end
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (obs !== E_WAIT) begin errors++; $display("FAIL midreset_idle obs=%b exp=%b", obs, E_WAIT); end
        checks++;
        if (write_seen !== 1'b0) begin errors++; $display("FAIL midreset_write got=%b exp=0", write_seen); end
        watch_write = 1'b0;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 5; k++) begin
            start(3'b110, 2'b10);
            tick();
            checks++;
            if (obs_n !== E_WIMM) begin errors++; $display("FAIL wrap_wimm[%0d] obs=%b exp=%b", k, obs_n, E_WIMM); end
            tick();
        end
        checks++;
        if (instr_count !== 16'd5) begin errors++; $display("FAIL wrap_wide got=%0d exp=5", instr_count); end
        checks++;
        if (n_instr_count !== 2'd1) begin errors++; $display("FAIL wrap_narrow got=%0d exp=1", n_instr_count); end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_mvn_mov(3'b101, 2'b11, 16'd4);
        test_mvn_mov(3'b110, 2'b00, 16'd5);
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
